// File: rtl/cola_pkg.sv
// Shared definitions for the cola buyer: FSM encoding and default parameters.
// The 3-bit state width matches the vending machine this block drives.
package cola_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PAY  = 3'd1,
      ST_GAP  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int PRICE_DEF   = 3;  // coins per cola
   localparam int GAP_DEF     = 1;  // idle cycles between coins
   localparam int TIMEOUT_DEF = 4;  // cycles to wait for a cola
   localparam int CNT_W_DEF   = 4;  // purchase / cola counter width

endpackage

// File: rtl/cola_buyer_timer.sv
// Loadable up-counter with terminal-count flag. The same counter paces the
// idle cycles between coins and the wait for a delivered cola.
// hit is high on the enabled cycle that completes 'max' counted cycles, so a
// caller leaving its state on hit spends exactly 'max' cycles there.
// The count saturates at 'max'; clr has priority over en.
module buy_timer #(
   parameter int W = 3
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max,
   output logic         hit
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != max)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = en && (cnt_q == (max - W'(1)));

endmodule

// File: rtl/cola_buyer.sv
// Customer-side driver for the cola vending machine. Pays PRICE one-cycle
// coin pulses per cola (GAP idle cycles apart), waits up to TIMEOUT cycles
// for the machine's cola pulse, and repeats until buy_num colas arrived.
//
// Handshake: buy_req is a single-cycle strobe honoured only in IDLE, with
// buy_num sampled on the same edge; everything else ignores it. A purchase
// ends with exactly one done pulse, or with an err pulse on timeout. err also
// pulses for any cola arriving outside the wait window, without other effect.
//
// pi_cola is registered once on entry, so every reaction to it (count, done,
// err) happens one cycle after the pulse. This also lets a machine that
// answers combinationally during the last coin be counted correctly.
// All outputs are registered and aligned with the state they belong to.
module cola_buyer
   import cola_pkg::*;
#(
   parameter int PRICE   = PRICE_DEF,
   parameter int GAP     = GAP_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             buy_req,
   input  logic [CNT_W-1:0] buy_num,
   output logic             po_money,
   input  logic             pi_cola,
   output logic             busy,
   output logic [CNT_W-1:0] cola_cnt,
   output logic             done,
   output logic             err,
   output logic [2:0]       dbg_state_o
);

   localparam int COIN_W  = $clog2(PRICE + 1);
   localparam int TMR_MAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    num_q, num_d;
   logic [CNT_W-1:0]    cola_cnt_q, cola_cnt_d;
   logic [COIN_W-1:0]   coins_q, coins_d;
   logic                pi_cola_q;
   logic                po_money_q, po_money_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                tmr_clr;
   logic                tmr_en;
   logic [TMR_W-1:0]    tmr_max;
   logic                tmr_hit;

   // After a coin or a delivery: pause GAP cycles, or pay straight away.
   state_e              st_after_coin;
   assign st_after_coin = (GAP == 0) ? ST_PAY : ST_GAP;

   // The timer restarts on every state change and runs only while pacing
   // coins or waiting for a cola.
   assign tmr_clr = (state_d != state_q);
   assign tmr_en  = (state_q == ST_GAP) || (state_q == ST_WAIT);
   assign tmr_max = (state_q == ST_GAP) ? TMR_W'(GAP) : TMR_W'(TIMEOUT);

   buy_timer #(
      .W (TMR_W)
   ) u_timer (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .max     (tmr_max),
      .hit     (tmr_hit)
   );

   // Next-state, counters and registered output values.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      cola_cnt_d = cola_cnt_q;
      coins_d    = coins_q;
      err_d      = pi_cola_q && (state_q != ST_WAIT);

      case (state_q)
         ST_IDLE: begin
            if (buy_req) begin
               cola_cnt_d = '0;
               coins_d    = '0;
               if (buy_num != '0) begin
                  num_d   = buy_num;
                  state_d = ST_PAY;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_PAY: begin
            coins_d = coins_q + COIN_W'(1);
            if (coins_q == COIN_W'(PRICE - 1)) begin
               state_d = ST_WAIT;
            end else begin
               state_d = st_after_coin;
            end
         end
         ST_GAP: begin
            if (tmr_hit) begin
               state_d = ST_PAY;
            end
         end
         ST_WAIT: begin
            // A delivery on the timeout cycle still counts as a delivery.
            if (pi_cola_q) begin
               cola_cnt_d = cola_cnt_q + CNT_W'(1);
               coins_d    = '0;
               if ((cola_cnt_q + CNT_W'(1)) == num_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = st_after_coin;
               end
            end else if (tmr_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      po_money_d = (state_d == ST_PAY);
      busy_d     = (state_d == ST_PAY) || (state_d == ST_GAP) || (state_d == ST_WAIT);
      done_d     = (state_d == ST_DONE);
   end

   // State, counters, input capture and output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         cola_cnt_q <= '0;
         coins_q    <= '0;
         pi_cola_q  <= 1'b0;
         po_money_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         cola_cnt_q <= cola_cnt_d;
         coins_q    <= coins_d;
         pi_cola_q  <= pi_cola;
         po_money_q <= po_money_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign po_money    = po_money_q;
   assign busy        = busy_q;
   assign cola_cnt    = cola_cnt_q;
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/cola_buyer.md
Name: cola_buyer

Overview:
- Customer-side initiator for the cola vending state machine: on a purchase request, emits one-cycle coin pulses (po_money) that drive the vending machine's pi_money input, and collects its po_cola pulses.
- Counts the colas delivered and reports completion.
- Raises an error on a delivery timeout or an unexpected cola.
- Serves as a reusable stimulus and driver block for vending-machine system tests and board demos.

Parameters:
PRICE, 3, coins per cola (the vending machine dispenses after PRICE coins)
GAP, 1, idle cycles between consecutive coin pulses (0 = back-to-back coins)
TIMEOUT, 4, cycles to wait for pi_cola after the last coin of a cola before flagging an error
CNT_W, 4, width of the purchase and cola counters

Ports:
sys_clk  in  1  system clock, all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
buy_req  in  1  one-cycle purchase request; sampled only in IDLE
buy_num  in  CNT_W  number of colas to buy; latched with buy_req
po_money  out  1  coin pulse to the vending machine (1 coin per high cycle), registered
pi_cola  in  1  cola-delivered pulse from the vending machine
busy  out  1  high from the cycle after an accepted buy_req until the DONE or error return to IDLE
cola_cnt  out  CNT_W  colas received in the current or last purchase
done  out  1  one-cycle pulse when all buy_num colas have been received
err  out  1  one-cycle pulse on timeout or unexpected pi_cola

Behaviour:
- Reset: synchronous, active-high, takes effect on the same edge. State=IDLE; po_money=0, busy=0, cola_cnt=0, done=0, err=0; internal coin count and timer cleared.
- Reset mid-purchase aborts immediately. No further coins are sent and partial counts are discarded.
- FSM states: IDLE, PAY, GAP, WAIT_COLA, DONE.
- IDLE:
  - buy_req=1 with buy_num!=0: latch buy_num, clear cola_cnt and coin count, go to PAY.
  - buy_req=1 with buy_num=0: go to DONE. No coins are sent and cola_cnt is cleared.
  - buy_req is ignored in every other state.
- PAY:
  - po_money=1 for exactly this cycle; coin count increments.
  - If coin count reaches PRICE: go to WAIT_COLA with the timer cleared.
  - Otherwise go to GAP, or stay in PAY when GAP=0.
- GAP: po_money=0 for GAP cycles, then PAY.
- WAIT_COLA:
  - Timer increments each cycle.
  - pi_cola=1: cola_cnt+1 and coin count cleared. If the new cola_cnt equals the latched buy_num, go to DONE; otherwise go to GAP (or PAY when GAP=0).
  - Timer reaches TIMEOUT with no pi_cola: err=1 for one cycle, then IDLE. cola_cnt holds its partial value.
- DONE: done=1 for one cycle, busy deasserts, then IDLE. cola_cnt holds until the next accepted request.
- pi_cola in any state other than WAIT_COLA: err pulse; the pulse is otherwise ignored and the state is unchanged.
- Timing, request accepted at edge N:
  - Coins are high in cycles N+1, N+1+(GAP+1), and so on.
  - With PRICE=3 and GAP=1, the first cola's coins occupy cycles N+1, N+3, N+5, and WAIT_COLA starts at N+6.
  - A machine with a registered po_cola answers in N+6. That cola is counted at edge N+7.
- Counter rules: cola_cnt and coin count never wrap, since buy_num ≤ 2^CNT_W−1 bounds them. The timer saturates at TIMEOUT.
- Simultaneous events: pi_cola on the same cycle the timer reaches TIMEOUT counts as a delivery, and no err is raised.

Decomposition:
- Shared package cola_pkg:
  - State encoding localparams (IDLE=0, PAY=1, GAP=2, WAIT_COLA=3, DONE=4; 3 bits, matching the vending machine's 3-bit state width).
  - Default PRICE=3.
- Sub-module buy_timer:
  - A loadable up-counter with a terminal-count flag.
  - Used for both the GAP spacing and the TIMEOUT wait.
  - Ports: sys_clk, sys_rst, clr, en, max, hit.

Test Plan:
- Single cola: buy_req with buy_num=1, PRICE=3, GAP=1, machine model answers one cycle after the third coin → po_money high at N+1, N+3, N+5; cola_cnt=1; done at N+8; err never asserted.
- Multi-purchase: buy_num=3 → exactly 9 coin pulses, cola_cnt steps 1,2,3, one done pulse, busy low afterwards.
- Timeout: model never answers, TIMEOUT=4 → 3 coins, err pulse 4 cycles into WAIT_COLA, return to IDLE, cola_cnt=0, no done.
- Protocol errors: spurious pi_cola during GAP → err pulse, coin sequence continues unchanged. buy_req while busy → ignored. buy_num=0 → done next cycle and zero coins.
- Reset mid-operation: sys_rst=1 after the second coin → next cycle po_money=0, busy=0, cola_cnt=0. A new buy_req after reset restarts cleanly with 3 coins.
- Back-to-back: GAP=0, buy_num=2 → coins in 3 consecutive cycles, WAIT_COLA, then 3 more consecutive coins, done, cola_cnt=2.
